// File: rtl/log_capture_ctrl_pkg.sv
// log_capture_ctrl_pkg: default sizes and FSM state encodings for the debug log capture controller
package log_capture_ctrl_pkg;
  localparam int LOG_DEPTH = 32768;
  localparam int LOG_ADDR_W = 15;
  localparam int LOG_DECIM_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } log_state_e;
endpackage

// File: rtl/log_capture_ctrl_if.sv
// log_capture_ctrl_if: micro/datapath control in (run, trigger, decim), RAM write strobe/address and status out
interface log_capture_ctrl_if import log_capture_ctrl_pkg::*; #(
  parameter int ADDR_W = LOG_ADDR_W,
  parameter int DECIM_W = LOG_DECIM_W
);
  logic run;
  logic trigger;
  logic [DECIM_W-1:0] decim;
  logic write;
  logic [ADDR_W-1:0] address;
  logic full;
  logic busy;
  logic [1:0] state_dbg;
  modport master(output run, trigger, decim, input write, address, full, busy, state_dbg);
  modport slave(input run, trigger, decim, output write, address, full, busy, state_dbg);
endinterface

// File: rtl/log_capture_ctrl_mod_m_counter.sv
// log_capture_ctrl_mod_m_counter: mod-M counter (clk, async rst, sync clr, run enable -> q, max at M-1)
module log_capture_ctrl_mod_m_counter #(
  parameter int M = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         run,
  output logic [W-1:0] q,
  output logic         max
);
  logic [W-1:0] cnt_q, cnt_d;
  assign max = cnt_q == W'(M - 1);
  assign q = cnt_q;
  always_comb cnt_d = clr ? '0 : run ? (max ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: arms on run rise, optionally waits for trigger (LOG_TRIGGER_EN), writes DEPTH words every decim+1 clocks
module log_capture_ctrl import log_capture_ctrl_pkg::*; #(
  parameter int DEPTH = LOG_DEPTH,
  parameter int ADDR_W = LOG_ADDR_W,
  parameter int DECIM_W = LOG_DECIM_W
) (
  input logic              clockdsp,
  input logic              soft_reset,
  log_capture_ctrl_if.slave bus
);
`ifdef LOG_TRIGGER_EN
  localparam log_state_e arm_state = ST_WAIT_TRIG;
`else
  localparam log_state_e arm_state = ST_CAPTURE;
`endif
  log_state_e state_q, state_d;
  logic run_q, rise, fall, write, max;
  logic [DECIM_W-1:0] decim_q, decim_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] address;
  assign rise = bus.run & ~run_q;
  assign fall = ~bus.run & run_q;
  assign write = state_q == ST_CAPTURE && cnt_q == '0;
  always_comb begin
    decim_d = (state_q == ST_IDLE && rise) ? bus.decim : decim_q;
    cnt_d = (state_q != ST_CAPTURE || cnt_q == decim_q) ? '0 : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE:      state_d = rise ? arm_state : ST_IDLE;
      ST_WAIT_TRIG: state_d = fall ? ST_IDLE : bus.trigger ? ST_CAPTURE : ST_WAIT_TRIG;
      ST_CAPTURE:   state_d = fall ? ST_IDLE : (write && max) ? ST_DONE : ST_CAPTURE;
      default:      state_d = fall ? ST_IDLE : ST_DONE;
    endcase
  end
  always_ff @(posedge clockdsp or posedge soft_reset)
    if (soft_reset) begin
      state_q <= ST_IDLE;
      run_q <= 1'b0;
      decim_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= bus.run;
      decim_q <= decim_d;
      cnt_q <= cnt_d;
    end
  log_capture_ctrl_mod_m_counter #(.M(DEPTH), .W(ADDR_W)) u_addr (
    .clk(clockdsp),
    .rst(soft_reset),
    .clr(state_d == ST_IDLE),
    .run(write),
    .q(address),
    .max(max)
  );
  assign bus.write = write;
  assign bus.address = address;
  assign bus.full = state_q == ST_DONE;
  assign bus.busy = state_q == ST_WAIT_TRIG || state_q == ST_CAPTURE;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb_log_capture_ctrl: directed self-checking bench for log_capture_ctrl with DEPTH=16
module tb_log_capture_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  log_capture_ctrl_if #(.ADDR_W(4), .DECIM_W(8)) bus ();
  log_capture_ctrl #(.DEPTH(16), .ADDR_W(4), .DECIM_W(8)) dut (
    .clockdsp(clk),
    .soft_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic arm(input int d);
    bus.run = 1'b0;
    tick();
    bus.decim = 8'(d);
    bus.run = 1'b1;
    tick();
`ifdef LOG_TRIGGER_EN
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
`endif
  endtask
  task automatic capture(input int d, input string tag);
    for (int c = 0; c < 16 * (d + 1) - d; c++) begin
      if (c == 5) bus.decim = 8'd0;
      check({tag, "_wr"}, 32'(bus.write), 32'((c % (d + 1)) == 0));
      if (c % (d + 1) == 0) check({tag, "_addr"}, 32'(bus.address), c / (d + 1));
      tick();
    end
    check({tag, "_full"}, 32'(bus.full), 1);
    check({tag, "_done_wr"}, 32'(bus.write), 0);
    check({tag, "_done_busy"}, 32'(bus.busy), 0);
    check({tag, "_done_st"}, 32'(bus.state_dbg), 3);
    check({tag, "_done_addr"}, 32'(bus.address), 0);
  endtask
  initial begin
    bus.run = 1'b0;
    bus.trigger = 1'b0;
    bus.decim = 8'd0;
    tick();
    tick();
    check("rst_wr", 32'(bus.write), 0);
    check("rst_addr", 32'(bus.address), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_st", 32'(bus.state_dbg), 0);
    rst = 1'b0;
    tick();
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    check("idle_trig_st", 32'(bus.state_dbg), 0);
    check("idle_trig_wr", 32'(bus.write), 0);
    arm(0);
    capture(0, "t1");
    bus.run = 1'b0;
    bus.trigger = 1'b0;
    tick();
    check("t5_fall_full", 32'(bus.full), 0);
    check("t5_fall_st", 32'(bus.state_dbg), 0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    tick();
`ifdef LOG_TRIGGER_EN
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
`endif
    capture(0, "t5");
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    tick();
    check("t5_rise_in_idle_after_done", 32'(bus.busy), 1);
    bus.run = 1'b0;
    tick();
    arm(2);
    capture(2, "t2");
    arm(0);
    repeat (5) tick();
    check("t3_addr5", 32'(bus.address), 5);
    bus.run = 1'b0;
    tick();
    check("t3_abort_wr", 32'(bus.write), 0);
    check("t3_abort_full", 32'(bus.full), 0);
    check("t3_abort_addr", 32'(bus.address), 0);
    check("t3_abort_st", 32'(bus.state_dbg), 0);
    tick();
    check("t3_quiet_wr", 32'(bus.write), 0);
`ifdef LOG_TRIGGER_EN
    bus.decim = 8'd0;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_wait_wr", 32'(bus.write), 0);
      check("t4_wait_busy", 32'(bus.busy), 1);
      check("t4_wait_st", 32'(bus.state_dbg), 1);
      tick();
    end
    bus.run = 1'b0;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    check("t4_fall_wins_st", 32'(bus.state_dbg), 0);
    bus.run = 1'b1;
    tick();
    check("t4_rearm_st", 32'(bus.state_dbg), 1);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    capture(0, "t4");
    bus.run = 1'b0;
    tick();
`else
    bus.decim = 8'd0;
    bus.run = 1'b1;
    tick();
    check("t4_notrig_st", 32'(bus.state_dbg), 2);
    check("t4_notrig_wr", 32'(bus.write), 1);
    check("t4_notrig_addr", 32'(bus.address), 0);
    bus.run = 1'b0;
    tick();
`endif
    arm(0);
    repeat (7) tick();
    check("t6_pre_addr", 32'(bus.address), 7);
    check("t6_pre_wr", 32'(bus.write), 1);
    rst = 1'b1;
    #1;
    check("t6_async_wr", 32'(bus.write), 0);
    check("t6_async_addr", 32'(bus.address), 0);
    check("t6_async_st", 32'(bus.state_dbg), 0);
    check("t6_async_busy", 32'(bus.busy), 0);
    tick();
    tick();
    check("t6_held_st", 32'(bus.state_dbg), 0);
    check("t6_held_wr", 32'(bus.write), 0);
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t6_post_st", 32'(bus.state_dbg), 0);
    check("t6_post_wr", 32'(bus.write), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
